// File: rtl/div_seq_pkg.sv
// Shared constants and types for the 8-bit sequential divider.
//   WIDTH  : operand width (fixed at 8 by the subtractor datapath)
//   CNT_W  : iteration counter width (8 iterations)
//   S_*    : controller state encodings
//   div_result_t : result payload (quotient, remainder, divide-by-zero flag)
package div_seq_pkg;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned CNT_W = 3;
   localparam int unsigned ST_W  = 2;

   localparam logic [ST_W-1:0] S_IDLE = 2'd0;
   localparam logic [ST_W-1:0] S_RUN  = 2'd1;
   localparam logic [ST_W-1:0] S_DONE = 2'd2;

   typedef struct packed {
      logic [WIDTH-1:0] quot;
      logic [WIDTH-1:0] rem;
      logic             dbz;
   } div_result_t;

endpackage

// File: rtl/subtractor_8bit.sv
// Existing 8-bit subtractor datapath: s = a - b (modulo 256).
//   a : minuend
//   b : subtrahend
//   s : difference, wraps modulo 256
module subtractor_8bit (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] s
);

   assign s = a - b;

endmodule

// File: rtl/div_sequencer_8bit.sv
// Sequential 8-bit unsigned restoring divider controller. Sequences one
// subtractor_8bit instance for eight iterations and returns quotient and
// remainder with a one-cycle done pulse.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : request, sampled only in IDLE
//   dividend    : unsigned dividend, latched on accept
//   divisor     : unsigned divisor, latched on accept
//   busy        : high while an operation is in flight
//   done        : one-cycle completion pulse
//   quotient    : result, held until the next completion
//   remainder   : result, held until the next completion
//   div_by_zero : divisor was zero (only when DIV_SEQ_ZERO_CHECK_EN is defined)
// Optional feature macro: DIV_SEQ_ZERO_CHECK_EN (zero divisor finishes after one edge).
module div_sequencer_8bit
   import div_seq_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   logic [ST_W-1:0]  state_q, state_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   div_result_t      res_q, res_d;

   logic [WIDTH-1:0] r_shift_c;
   logic [WIDTH-1:0] diff_c;
   logic             carry_c;
   logic             take_c;
   logic             zero_skip_c;

   // Partial remainder shifted with the next dividend bit; the bit that falls
   // off the top acts as the 9th bit, so a modulo-256 difference stays exact.
   assign r_shift_c = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
   assign carry_c   = r_q[WIDTH-1];
   assign take_c    = carry_c | (r_shift_c >= d_q);

   subtractor_8bit u_sub (
      .a (r_shift_c),
      .b (d_q),
      .s (diff_c)
   );

`ifdef DIV_SEQ_ZERO_CHECK_EN
   assign zero_skip_c = (d_q == '0);
`else
   assign zero_skip_c = 1'b0;
`endif

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         d_q     <= '0;
         q_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
         q_q     <= q_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         res_q   <= res_d;
      end
   end

   // Next-state and datapath control
   always_comb begin
      state_d = state_q;
      d_d     = d_q;
      q_d     = q_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      res_d   = res_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               d_d       = divisor;
               q_d       = dividend;
               r_d       = '0;
               cnt_d     = '0;
               busy_d    = 1'b1;
               res_d.dbz = 1'b0;
               state_d   = S_RUN;
            end
         end

         S_RUN: begin
            if (zero_skip_c) begin
               // Dividend is still untouched in Q, so it is the remainder.
               res_d.quot = '1;
               res_d.rem  = q_q;
               res_d.dbz  = 1'b1;
               busy_d     = 1'b0;
               done_d     = 1'b1;
               state_d    = S_DONE;
            end else begin
               q_d   = {q_q[WIDTH-2:0], take_c};
               r_d   = take_c ? diff_c : r_shift_c;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(7)) begin
                  res_d.quot = q_d;
                  res_d.rem  = r_d;
                  busy_d     = 1'b0;
                  done_d     = 1'b1;
                  state_d    = S_DONE;
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = res_q.quot;
   assign remainder   = res_q.rem;
   assign div_by_zero = res_q.dbz;

endmodule
